imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Boot-time writer for the instruction ROM: receives a program as a byte stream over a valid/ready port.
//   Packs the bytes big-endian into 32-bit words and issues one write per word into instruction memory from byte address 0.
//   Holds the CPU core in reset, via cpu_rstn, until the whole program is loaded.
//   Sits beside the instruction memory, driving its write port; the core fetches through the read port.
// PARAMETERS
//   byte               8    bits per stream beat
//   instruction_width  32   word and address width
//   rom_depth          256  instruction memory size in bytes; max words = rom_depth/4 = 64
// PORTS
//   clk         in   1   clock, rising edge
//   rstn        in   1   async active-low reset
//   start       in   1   one-cycle pulse, begins a load
//   s_data      in   8   stream byte
//   s_valid     in   1   s_data is valid
//   s_ready     out  1   loader accepts a byte; transfer = s_valid & s_ready
//   imem_we     out  1   instruction memory write strobe, one cycle per word
//   imem_addr   out  32  byte address of the write (word_idx*4)
//   imem_wdata  out  32  instruction word
//   cpu_rstn    out  1   active-low reset to the core
//   busy        out  1   load in progress
//   done        out  1   load completed OK (level)
//   err         out  1   load aborted (level)
// BEHAVIOUR
//   Reset: state IDLE; word_idx=0; all outputs 0, including cpu_rstn=0 (core held in reset).
//   Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N x 4 data bytes, MSB first.
//   FSM states: IDLE -> LEN_HI -> LEN_LO -> DATA -> [CHK] -> DONE | ERR.
//   Exit from IDLE/DONE/ERR happens only on start, to LEN_HI. On that transition cpu_rstn<=0, done<=0, err<=0, word_idx<=0.
//   start in LEN_HI/LEN_LO/DATA/CHK is ignored.
//   s_ready=1 only in LEN_HI, LEN_LO, DATA, CHK. The state moves only on an accepted byte; s_valid with s_ready=0 is not consumed.
//   At the LEN_LO accept:
//     - N==0 goes to DONE.
//     - N>rom_depth/4 goes to ERR.
//     - Otherwise goes to DATA.
//   DATA: 2-bit byte counter; the 4th byte completes the word. imem_we=1 on the next cycle, with imem_addr=word_idx*4 and
//   imem_wdata=assembled word, both registered and held until the next write. word_idx increments with the write.
//   imem_we is never high for two consecutive cycles.
//   After the last word's 4th byte at cycle t: imem_we=1 at t+1; state DONE and done=1 at t+1; cpu_rstn=1 at t+2.
//   The core therefore never leaves reset before the last write lands.
//   DONE: cpu_rstn stays 1 until the next start or rstn.
//   ERR: err=1, cpu_rstn=0, no further writes; exit only via start or rstn.
//   busy=1 in LEN_HI, LEN_LO, DATA, CHK.
//   rstn asserted mid-load: immediate return to the reset values; a partially written ROM is left as is; imem_we drops at once.
//   Address arithmetic: word_idx is 6 bits and cannot wrap, because N is bounded at LEN_LO.
// CONFIGURATION
//   LOADER_CHECKSUM_EN defined:
//     - After the last data byte the FSM enters CHK and accepts one byte.
//     - If that byte equals the XOR of all data bytes (length bytes excluded), go to DONE; otherwise go to ERR.
//     - The t+1/t+2 timing applies from the checksum byte.
//     - With N==0 the FSM still expects the checksum byte, which must be 0x00.
//   Not defined: there is no CHK state and DATA goes straight to DONE.
// STRUCTURE
//   Shared package/header: FSM state encoding localparams, HDR_BYTES=2, MAX_WORDS=rom_depth/4, BYTES_PER_WORD=4.
//   Sub-module imem_byte_packer:
//     - 32-bit shift register with a byte counter.
//     - Outputs word_valid, pulsing with the 4th byte.
//     - With LOADER_CHECKSUM_EN it also keeps a running XOR.
//   The top level holds the FSM, the length/index counters, and the write and cpu_rstn registers.
// TESTING
//   1) start; bytes 00 02 20 01 00 05 8C 22 00 04 with s_valid held.
//      -> imem_we pulses: (addr 0x0, 0x20010005) and (addr 0x4, 0x8C220004).
//      -> done=1 one cycle after the last byte; cpu_rstn=1 one cycle later.
//   2) Same stream with s_valid toggled every other cycle.
//      -> identical writes; no byte lost or duplicated; imem_we only after each 4th accepted byte.
//   3) Header 00 41 (65 > 64 words).
//      -> err=1 after LEN_LO; no imem_we; cpu_rstn stays 0.
//   4) Header 00 00.
//      -> done=1 with no writes (macro off). With LOADER_CHECKSUM_EN the bench also sends 00 -> done.
//   5) rstn pulsed low after 5 data bytes, then a new start with test 1's stream.
//      -> outputs clear asynchronously; the reload writes both words correctly.
//   6) LOADER_CHECKSUM_EN: test 1 stream plus 8E -> done. Plus 8F -> err=1, cpu_rstn=0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants, FSM state encoding and address helper for the instruction-memory boot loader.
// Optional checksum trailer is enabled by defining LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int INSTR_W        = 32;
  localparam int ROM_DEPTH      = 256;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int MAX_WORDS      = ROM_DEPTH / BYTES_PER_WORD;
  localparam int IDX_W          = $clog2(MAX_WORDS);
  localparam int WCNT_W         = IDX_W + 1;
  localparam int LEN_W          = HDR_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic logic [INSTR_W-1:0] word_addr(input logic [IDX_W-1:0] idx);
    return INSTR_W'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready port feeding the loader; the program source is the master.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic [BYTE_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/imem_byte_packer.sv
// Packs accepted data bytes big-endian into 32-bit words; with LOADER_CHECKSUM_EN it also
// keeps the running XOR of every data byte since the last clear.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               clear_i,
  input  logic               byte_valid_i,
  input  logic [BYTE_W-1:0]  byte_i,
  output logic               word_valid_o,
  output logic [INSTR_W-1:0] word_o
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [BYTE_W-1:0]  csum_o
`endif
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]          cnt_q;
  // The leading three bytes are held here; the fourth completes the word on the fly.
  logic [INSTR_W-BYTE_W-1:0] sr_q;

  assign word_valid_o = byte_valid_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
  assign word_o       = {sr_q, byte_i};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (byte_valid_i) begin
      cnt_q <= cnt_q + 1'b1;
      sr_q  <= {sr_q[INSTR_W-2*BYTE_W-1:0], byte_i};
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      csum_q <= '0;
    end else if (clear_i) begin
      csum_q <= '0;
    end else if (byte_valid_i) begin
      csum_q <= csum_q ^ byte_i;
    end
  end

  assign csum_o = csum_q;
`endif

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction ROM writer: length header + big-endian words over a byte stream,
// core held in reset until the load completes. Define LOADER_CHECKSUM_EN for the XOR trailer.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  imem_loader_if.slave       s,
  output logic               imem_we,
  output logic [INSTR_W-1:0] imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_rstn,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e              state_q;
  logic [BYTE_W-1:0]   len_hi_q;
  logic [WCNT_W-1:0]   len_q;
  logic [IDX_W-1:0]    word_idx_q;
  logic                imem_we_q;
  logic [INSTR_W-1:0]  imem_addr_q;
  logic [INSTR_W-1:0]  imem_wdata_q;
  logic                cpu_rstn_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic                accept;
  logic                load_start;
  logic                data_beat;
  logic                word_valid;
  logic [INSTR_W-1:0]  word;
  logic [LEN_W-1:0]    len_d;
  logic                last_word;

  // s_ready tracks busy exactly, so a beat is consumed only in a stream-facing state.
  assign accept     = s.s_valid & busy_q;
  assign load_start = start & ~busy_q;
  assign data_beat  = accept & (state_q == ST_DATA);
  assign len_d      = {len_hi_q, s.s_data};
  assign last_word  = (WCNT_W'(word_idx_q) + 1'b1) == len_q;

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  imem_byte_packer u_packer (
    .clk          (clk),
    .rstn         (rstn),
    .clear_i      (load_start),
    .byte_valid_i (data_beat),
    .byte_i       (s.s_data),
    .word_valid_o (word_valid),
    .word_o       (word)
`ifdef LOADER_CHECKSUM_EN
    ,
    .csum_o       (csum)
`endif
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      len_hi_q     <= '0;
      len_q        <= '0;
      word_idx_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rstn_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // The core leaves reset one cycle after DONE is reached.
          if (state_q == ST_DONE) cpu_rstn_q <= 1'b1;
          if (start) begin
            state_q    <= ST_LEN_HI;
            busy_q     <= 1'b1;
            cpu_rstn_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            word_idx_q <= '0;
          end
        end

        ST_LEN_HI: begin
          if (accept) begin
            len_hi_q <= s.s_data;
            state_q  <= ST_LEN_LO;
          end
        end

        ST_LEN_LO: begin
          if (accept) begin
            if (len_d == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= ST_CHK;
`else
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else if (len_d > LEN_W'(MAX_WORDS)) begin
              state_q <= ST_ERR;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_DATA;
              len_q   <= len_d[WCNT_W-1:0];
            end
          end
        end

        ST_DATA: begin
          if (word_valid) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= word_addr(word_idx_q);
            imem_wdata_q <= word;
            word_idx_q   <= word_idx_q + 1'b1;
            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= ST_CHK;
`else
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (accept) begin
            busy_q <= 1'b0;
            if (s.s_data == csum) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s.s_ready  = busy_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rstn   = cpu_rstn_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts every ROM write and the final
// outcome; a negedge monitor checks each write, plus hand-computed timing and value checks.
module tb_imem_loader;
  import imem_loader_pkg::*;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

`ifdef LOADER_CHECKSUM_EN
  localparam logic EXP_WE_AT_END = 1'b0;
`else
  localparam logic EXP_WE_AT_END = 1'b1;
`endif

  logic        clk   = 1'b0;
  logic        rstn  = 1'b1;
  logic        start = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rstn;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader_if s_if ();

  imem_loader dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .s          (s_if),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rstn   (cpu_rstn),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Model: parse the stream as header + words and predict writes and the final verdict.
  task automatic model_load(input byte_q_t b, output bit exp_ok);
    int          n;
    logic [7:0]  x;
    wr_t         w;
    n      = int'({b[0], b[1]});
    x      = 8'h00;
    exp_ok = (n <= MAX_WORDS);
    if (exp_ok) begin
      for (int i = 0; i < n; i++) begin
        w.addr = 32'(i * BYTES_PER_WORD);
        w.data = {b[HDR_BYTES + 4*i], b[HDR_BYTES + 4*i + 1],
                  b[HDR_BYTES + 4*i + 2], b[HDR_BYTES + 4*i + 3]};
        exp_q.push_back(w);
        for (int k = 0; k < 4; k++) x ^= b[HDR_BYTES + 4*i + k];
      end
`ifdef LOADER_CHECKSUM_EN
      exp_ok = (b[b.size() - 1] == x);
`endif
    end
  endtask

  // Monitor: every write must match the model, never back to back, and the core
  // may leave reset only once all predicted writes have landed.
  logic prev_we  = 1'b0;
  logic prev_cpu = 1'b0;
  wr_t  mon_w;
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (imem_we) begin
          check("we_back_to_back", 32'(prev_we), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_we", 32'(imem_we), 32'd0);
          end else begin
            mon_w = exp_q.pop_front();
            check("wr_addr", imem_addr, mon_w.addr);
            check("wr_data", imem_wdata, mon_w.data);
          end
        end
        if (cpu_rstn && !prev_cpu) begin
          check("cpu_rstn_before_writes", 32'(exp_q.size()), 32'd0);
          check("cpu_rstn_without_done", 32'(done), 32'd1);
        end
      end
      prev_we  = imem_we;
      prev_cpu = cpu_rstn;
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    s_if.s_data  = b;
    s_if.s_valid = 1'b1;
    while (!s_if.s_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!s_if.s_ready) check("ready_timeout", 32'(s_if.s_ready), 32'd1);
    @(negedge clk);
    s_if.s_valid = 1'b0;
  endtask

  task automatic send_stream(input byte_q_t b, input bit toggle);
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i]);
      if (toggle && i != b.size() - 1) begin
        s_if.s_data = ~b[i];
        if (i == 4) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  task automatic finish_check(input string tag, input bit exp_ok);
    repeat (3) @(negedge clk);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done"}, 32'(done), 32'(exp_ok));
    check({tag, "_err"}, 32'(err), 32'(!exp_ok));
    check({tag, "_cpu_rstn"}, 32'(cpu_rstn), 32'(exp_ok));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, imem_addr, 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_cpu_rstn"}, 32'(cpu_rstn), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_s_ready"}, 32'(s_if.s_ready), 32'd0);
  endtask

  task automatic run_test1(input byte_q_t s1);
    bit ok;
    do_start();
    check("t1_busy_after_start", 32'(busy), 32'd1);
    model_load(s1, ok);
    send_stream(s1, 1'b0);
    check("t1_done_t1", 32'(done), 32'd1);
    check("t1_cpu_rstn_t1", 32'(cpu_rstn), 32'd0);
    check("t1_we_t1", 32'(imem_we), 32'(EXP_WE_AT_END));
    check("t1_addr_held", imem_addr, 32'h0000_0004);
    check("t1_wdata_held", imem_wdata, 32'h8C22_0004);
    @(negedge clk);
    check("t1_cpu_rstn_t2", 32'(cpu_rstn), 32'd1);
    check("t1_we_t2", 32'(imem_we), 32'd0);
    finish_check("t1", ok);
  endtask

  initial begin
    byte_q_t s1, s_big, s_zero, s_bad;
    bit      ok;

    s_if.s_data  = 8'h00;
    s_if.s_valid = 1'b0;
    s1     = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04};
    s_big  = '{8'h00, 8'h41};
    s_zero = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    s_bad  = s1;
    s_bad.push_back(8'h8F);
    s1.push_back(8'h8E);
    s_zero.push_back(8'h00);
`endif

    #2 rstn = 1'b0;
    #1 check_cleared("reset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // 1) back-to-back stream
    run_test1(s1);

    // 2) valid every other cycle, with a stray start pulse mid-load
    do_start();
    model_load(s1, ok);
    send_stream(s1, 1'b1);
    finish_check("t2", ok);

    // 3) oversize header
    do_start();
    model_load(s_big, ok);
    send_stream(s_big, 1'b0);
    check("t3_err_t1", 32'(err), 32'd1);
    check("t3_s_ready", 32'(s_if.s_ready), 32'd0);
    check("t3_cpu_rstn", 32'(cpu_rstn), 32'd0);
    finish_check("t3", ok);

    // 4) empty program
    do_start();
    model_load(s_zero, ok);
    send_stream(s_zero, 1'b0);
    check("t4_done_t1", 32'(done), 32'd1);
    finish_check("t4", ok);

    // 5) reset after five data bytes, then a clean reload
    do_start();
    model_load(s1, ok);
    for (int i = 0; i < HDR_BYTES + 5; i++) send_byte(s1[i]);
    check("t5_partial_writes_left", 32'(exp_q.size()), 32'd1);
    #2 rstn = 1'b0;
    #1 check_cleared("t5_async");
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    run_test1(s1);

`ifdef LOADER_CHECKSUM_EN
    // 6) wrong checksum trailer
    do_start();
    model_load(s_bad, ok);
    send_stream(s_bad, 1'b0);
    check("t6_err_t1", 32'(err), 32'd1);
    finish_check("t6", ok);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
